// File: rtl/packet_fifo_reader.sv
// ============================================================================
// packet_fifo_reader : drains packets from an fwft packet FIFO to a ready/valid
// stream, with per-packet drop, over-length truncation and statistics.
// Revision: 1.0
// ============================================================================
`default_nettype none

module packet_fifo_reader #(
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_PKT_LEN = 256,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_ren,
  output logic                  m_valid,
  output logic [DATA_WIDTH-2:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  input  logic                  drop_req,
  output logic [CNT_WIDTH-1:0]  pkt_cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt,
  output logic                  err,
  output logic                  busy
);

  localparam int WC_W = $clog2(MAX_PKT_LEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            drop_pend;
  logic            drop_by_req;
  logic            by_req_nxt;
  logic [WC_W-1:0] word_cnt;

  logic            pop_eop;
  logic            at_max;
  logic            load_out;
  logic            force_last;
  logic            pkt_inc;
  logic            drop_inc;
  logic            err_set;
  logic            pend_clr;
  logic            cnt_clr;

  assign pop_eop = fifo_rdata[DATA_WIDTH-1];
  assign at_max  = (word_cnt == WC_W'(MAX_PKT_LEN - 1));
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    by_req_nxt = drop_by_req;
    fifo_ren   = 1'b0;
    load_out   = 1'b0;
    force_last = 1'b0;
    pkt_inc    = 1'b0;
    drop_inc   = 1'b0;
    err_set    = 1'b0;
    pend_clr   = 1'b0;
    cnt_clr    = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        // A request arriving this very cycle already applies to this packet.
        if (!fifo_empty) begin
          if (drop_pend || drop_req) begin
            state_nxt  = DROP;
            pend_clr   = 1'b1;
            by_req_nxt = 1'b1;
          end else begin
            state_nxt = READ;
          end
        end
      end
      READ: begin
        fifo_ren = !m_valid || m_ready;
        if (fifo_ren) begin
          load_out = 1'b1;
          if (pop_eop) begin
            state_nxt = IDLE;
            pkt_inc   = 1'b1;
          end else if (at_max) begin
            force_last = 1'b1;
            err_set    = 1'b1;
            pkt_inc    = 1'b1;
            by_req_nxt = 1'b0;
            state_nxt  = DROP;
          end
        end
      end
      DROP: begin
        fifo_ren = 1'b1;
        if (pop_eop) begin
          state_nxt = IDLE;
          drop_inc  = drop_by_req;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_pend   <= 1'b0;
      drop_by_req <= 1'b0;
      word_cnt    <= '0;
      err         <= 1'b0;
      pkt_cnt     <= '0;
      drop_cnt    <= '0;
    end else begin
      drop_by_req <= by_req_nxt;
      if (pend_clr) begin
        drop_pend <= 1'b0;
      end else if (drop_req) begin
        drop_pend <= 1'b1;
      end
      if (cnt_clr) begin
        word_cnt <= '0;
      end else if (load_out && (word_cnt != WC_W'(MAX_PKT_LEN))) begin
        word_cnt <= word_cnt + 1'b1;
      end
      if (err_set) begin
        err <= 1'b1;
      end
      if (pkt_inc && (pkt_cnt != '1)) begin
        pkt_cnt <= pkt_cnt + 1'b1;
      end
      if (drop_inc && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  // Output register: a pop reloads it, an accepted beat without a pop empties it.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else if (load_out) begin
      m_valid <= 1'b1;
      m_data  <= fifo_rdata[DATA_WIDTH-2:0];
      m_last  <= pop_eop || force_last;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_packet_fifo_reader.sv
// ============================================================================
// tb_packet_fifo_reader : directed bench with fwft FIFO model and beat scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_packet_fifo_reader;

  localparam int DW   = 32;
  localparam int MAXL = 8;
  localparam int CW   = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_ren;
  logic          m_valid;
  logic [DW-2:0] m_data;
  logic          m_last;
  logic          m_ready;
  logic          drop_req;
  logic [CW-1:0] pkt_cnt;
  logic [CW-1:0] drop_cnt;
  logic          err;
  logic          busy;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;
  logic          ren_s;
  logic          rst_s;

  packet_fifo_reader #(
    .DATA_WIDTH (DW),
    .MAX_PKT_LEN(MAXL),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata),
    .fifo_ren  (fifo_ren),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .drop_req  (drop_req),
    .pkt_cnt   (pkt_cnt),
    .drop_cnt  (drop_cnt),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // The FIFO only shows non-empty once a complete packet (an eop word) is held.
  task automatic refresh();
    fifo_empty = 1'b1;
    foreach (fq[i]) if (fq[i][DW-1]) fifo_empty = 1'b0;
    fifo_rdata = (fq.size() != 0) ? fq[0] : '0;
  endtask

  // One clock: monitor at the falling edge, FIFO model update just after the rising edge.
  task automatic tick();
    logic [DW-1:0] e;
    @(negedge clk);
    ren_s = fifo_ren;
    rst_s = rst;
    if (!rst && m_valid && m_ready) begin
      chk("beat_expected", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("beat_data", {m_last, m_data}, e);
      end
    end
    if (!rst && ren_s) chk("pop_has_data", 64'(fq.size() != 0), 1);
    @(posedge clk);
    #1;
    if (rst_s) fq.delete();
    else if (ren_s && fq.size() != 0) void'(fq.pop_front());
    refresh();
    #1;
  endtask

  task automatic push_pkt(input int len, input int base, input bit fwd);
    logic [DW-1:0] w;
    for (int i = 0; i < len; i++) begin
      w = {(i == len - 1), 31'(base + i)};
      fq.push_back(w);
      if (fwd && i < MAXL) exp_q.push_back({(i == len - 1) || (i == MAXL - 1), 31'(base + i)});
    end
    refresh();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(fq.size() == 0 && exp_q.size() == 0 && !busy && !m_valid) && n < budget) begin
      tick();
      n++;
    end
    chk("idle_reached", 64'(fq.size() == 0 && exp_q.size() == 0 && !busy && !m_valid), 1);
  endtask

  initial begin
    rst      = 1'b1;
    m_ready  = 1'b1;
    drop_req = 1'b0;
    refresh();
    repeat (2) tick();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_fifo_ren", fifo_ren, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // Single 4-word packet, cycle-exact latency.
    push_pkt(4, 'h100, 1);
    for (int c = 0; c < 7; c++) begin
      chk("t1_ren", fifo_ren, 64'(c >= 1 && c <= 4));
      chk("t1_valid", m_valid, 64'(c >= 2 && c <= 5));
      chk("t1_last", m_last, 64'(c == 5));
      tick();
    end
    wait_idle(50);
    chk("t1_pkt_cnt", pkt_cnt, 1);

    // Backpressure on the first word.
    push_pkt(4, 'h200, 1);
    for (int c = 0; c < 7; c++) begin
      m_ready = !(c >= 2 && c <= 4);
      #1;
      if (c >= 2 && c <= 4) begin
        chk("t2_hold_valid", m_valid, 1);
        chk("t2_hold_data", m_data, 'h200);
        chk("t2_stall_ren", fifo_ren, 0);
      end
      tick();
    end
    m_ready = 1'b1;
    wait_idle(50);
    chk("t2_pkt_cnt", pkt_cnt, 2);

    // Drop request in IDLE applies to the next packet only.
    drop_req = 1'b1;
    tick();
    drop_req = 1'b0;
    tick();
    push_pkt(3, 'h300, 0);
    push_pkt(2, 'h310, 1);
    wait_idle(50);
    chk("t3_drop_cnt", drop_cnt, 1);
    chk("t3_pkt_cnt", pkt_cnt, 3);

    // Over-length packet truncated, remainder drained, next packet normal.
    chk("t4_err_before", err, 0);
    push_pkt(12, 'h400, 1);
    push_pkt(3, 'h420, 1);
    wait_idle(80);
    chk("t4_err", err, 1);
    chk("t4_pkt_cnt", pkt_cnt, 5);
    chk("t4_drop_cnt", drop_cnt, 1);

    // Drop request mid-packet: current completes, following one dropped.
    push_pkt(5, 'h500, 1);
    push_pkt(3, 'h520, 0);
    repeat (3) tick();
    chk("t5_busy", busy, 1);
    drop_req = 1'b1;
    tick();
    drop_req = 1'b0;
    wait_idle(50);
    chk("t5_drop_cnt", drop_cnt, 2);
    chk("t5_pkt_cnt", pkt_cnt, 6);

    // Reset on the 2nd word, with a simultaneous drop request.
    push_pkt(4, 'h600, 0);
    tick();
    tick();
    rst      = 1'b1;
    drop_req = 1'b1;
    tick();
    chk("t6_m_valid", m_valid, 0);
    chk("t6_m_last", m_last, 0);
    chk("t6_m_data", m_data, 0);
    chk("t6_fifo_ren", fifo_ren, 0);
    chk("t6_pkt_cnt", pkt_cnt, 0);
    chk("t6_drop_cnt", drop_cnt, 0);
    chk("t6_err", err, 0);
    chk("t6_busy", busy, 0);
    rst      = 1'b0;
    drop_req = 1'b0;
    tick();
    tick();
    chk("t6_ren_after", fifo_ren, 0);
    chk("t6_busy_after", busy, 0);
    push_pkt(2, 'h700, 1);
    wait_idle(50);
    chk("t6_pkt_cnt_after", pkt_cnt, 1);
    chk("t6_drop_cnt_after", drop_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/packet_fifo_reader.md
PACKET_FIFO_READER -- requirements
Module: packet_fifo_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32; FIFO word width, MSB = packet eop.
REQ-002 SHALL have parameter MAX_PKT_LEN, default 256; maximum words per packet, eop word included.
REQ-003 SHALL have parameter CNT_WIDTH, default 16; width of statistics counters.
REQ-004 SHALL have clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have fifo_empty  input  1  low only when the packet FIFO holds at least one complete packet (fwft read side).
REQ-007 SHALL have fifo_rdata  input  DATA_WIDTH  fwft head word; valid whenever fifo_empty is low or a packet is partly read.
REQ-008 SHALL have fifo_ren  output  1  pop strobe for the head word.
REQ-009 SHALL have m_valid  output  1  output word valid.
REQ-010 SHALL have m_data  output  DATA_WIDTH-1  payload, i.e. fifo_rdata[DATA_WIDTH-2:0].
REQ-011 SHALL have m_last  output  1  last word of the output packet.
REQ-012 SHALL have m_ready  input  1  downstream accept.
REQ-013 SHALL have drop_req  input  1  single-cycle request to discard the next packet to start.
REQ-014 SHALL have pkt_cnt, drop_cnt  output  CNT_WIDTH each  packets forwarded / discarded.
REQ-015 SHALL have err  output  1  sticky: over-length packet seen.
REQ-016 SHALL have busy  output  1  high when state is not IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, READ, DROP.
REQ-018 IDLE: no pop; if fifo_empty low, go to DROP when drop_pend=1 (clearing drop_pend), else go to READ; word_cnt cleared.
REQ-019 READ: fifo_ren = !m_valid || m_ready; fifo_empty is not checked mid-packet, since a complete packet is guaranteed present.
REQ-020 Each popped word in READ SHALL load the output register on the same edge: m_valid=1, m_data=rdata[DATA_WIDTH-2:0], m_last=rdata[MSB]. Word_cnt increments, saturating at MAX_PKT_LEN.
REQ-021 An output beat with m_valid && m_ready and no new pop SHALL clear m_valid; m_data/m_last SHALL hold while m_valid && !m_ready.
REQ-022 Popping the eop word in READ SHALL move to IDLE and increment pkt_cnt.
REQ-023 Popping word number MAX_PKT_LEN without eop SHALL:
- force m_last=1 on that word;
- set err;
- increment pkt_cnt;
- move to DROP.
REQ-024 DROP: fifo_ren=1 every cycle and no output. Popping an eop word moves to IDLE; drop_cnt increments only when DROP was entered via drop_pend.
REQ-025 drop_req SHALL set drop_pend in any state. drop_pend affects only the next IDLE->READ/DROP decision, never a packet already in progress; repeated requests before use collapse to one.
REQ-026 drop_req asserted in IDLE on the same cycle fifo_empty is low SHALL take effect for that packet.
REQ-027 Latency: fifo_empty falling at edge N gives READ at N+1, first pop at N+1 and m_valid at N+2. Back-to-back packets have exactly one idle cycle between eop pop and next first pop.
REQ-028 Throughput: with m_ready held high, one word per cycle within a packet.
REQ-029 pkt_cnt and drop_cnt SHALL saturate at all-ones.
REQ-030 fifo_ren SHALL never be high in IDLE, nor in READ/DROP after the eop pop.

Reset
REQ-031 rst high SHALL force, on the next edge:
- state=IDLE;
- m_valid=0, m_last=0, m_data=0;
- fifo_ren=0;
- pkt_cnt=0, drop_cnt=0;
- err=0, drop_pend=0, word_cnt=0;
- busy=0.
REQ-032 Reset mid-packet SHALL abandon the packet without further pops. Realigning the FIFO is the system reset's job, since FIFO and reader share one reset domain.
REQ-033 rst SHALL dominate drop_req and all FSM transitions in the same cycle.

Verification
REQ-034 Single 4-word packet, m_ready=1: fifo_empty falls at cycle 0 -> fifo_ren high cycles 1-4, m_valid cycles 2-5, m_last on cycle 5 only, pkt_cnt=1.
REQ-035 Backpressure: same packet, m_ready low cycles 2-4 -> first word held stable and fifo_ren low during stall, all 4 words delivered in order, no pop without acceptance room.
REQ-036 drop_req pulsed in IDLE, then 3-word packet followed by 2-word packet -> first packet popped in DROP with no m_valid, drop_cnt=1; second forwarded, pkt_cnt=1.
REQ-037 MAX_PKT_LEN=8, 12-word packet -> 8 words output with m_last on the 8th, err=1, 4 words silently drained, next packet forwarded normally.
REQ-038 drop_req pulsed mid-packet in READ -> current packet completes intact; following packet dropped.
REQ-039 rst asserted on the 2nd word of a packet -> next cycle all outputs at reset values, fifo_ren=0, counters 0.
